// File: rtl/pio_param_decoder_pkg.sv
// Shared field layout, reserved constants and FSM encoding for the PIO
// parameter decoder.
package pio_param_decoder_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TOGGLE_BIT = 31;
    localparam int unsigned IDX_MSB    = 30;
    localparam int unsigned IDX_LSB    = 27;
    localparam int unsigned RSV_MSB    = 26;
    localparam int unsigned RSV_LSB    = 24;
    localparam int unsigned VAL_W      = 24;
    localparam int unsigned CNT_W      = 8;

    localparam logic [3:0] IDX_CLR_ERR = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT
    } state_t;

    function automatic logic [3:0] word_idx(input logic [WORD_W-1:0] w);
        return w[IDX_MSB:IDX_LSB];
    endfunction

    function automatic logic word_rsv_set(input logic [WORD_W-1:0] w);
        return |w[RSV_MSB:RSV_LSB];
    endfunction

endpackage

// File: rtl/pio_word_stability.sv
// Registers the raw PIO word and tracks how long the captured command word
// has stayed unchanged.
module pio_word_stability
    import pio_param_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] i_pio_word,
    input  logic              i_capture,
    input  logic              i_settle,
    output logic              o_word_toggle,
    output logic [WORD_W-1:0] o_cap,
    output logic              o_stable,
    output logic              o_restart
);

    logic [WORD_W-1:0] r_word_q;
    logic [WORD_W-1:0] r_cap;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_restart;
    logic              w_stable;

    assign w_restart = (r_word_q != r_cap);
    assign w_stable  = !w_restart && (r_cnt == CNT_W'(STABLE_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_q <= '0;
            r_cap    <= '0;
            r_cnt    <= '0;
        end else begin
            r_word_q <= i_pio_word;
            if (i_capture || (i_settle && w_restart)) begin
                r_cap <= r_word_q;
                r_cnt <= CNT_W'(1);
            end else if (i_settle && !w_stable && (r_cnt != '1)) begin
                // Saturating count: never wraps back to a value that could match.
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_word_toggle = r_word_q[TOGGLE_BIT];
    assign o_cap         = r_cap;
    assign o_stable      = w_stable;
    assign o_restart     = w_restart;

endmodule

// File: rtl/pio_param_decoder.sv
// Decodes toggle-handshaked PIO command words into a bank of parameter
// registers, with an acknowledge toggle and a sticky command-error flag.
module pio_param_decoder
    import pio_param_decoder_pkg::*;
#(
    parameter int unsigned NUM_PARAMS    = 8,
    parameter int unsigned VALUE_W       = 24,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   pio_word,
    output logic [NUM_PARAMS*VALUE_W-1:0] param_bus,
    output logic [NUM_PARAMS-1:0]         param_update,
    output logic                          ack_toggle,
    output logic                          busy,
    output logic                          cmd_err
);

    state_t r_state;
    state_t w_state_n;

    logic [VALUE_W-1:0]    r_param [NUM_PARAMS];
    logic [NUM_PARAMS-1:0] r_update;
    logic                  r_last_toggle;
    logic                  r_ack;
    logic                  r_err;

    logic              w_word_toggle;
    logic [WORD_W-1:0] w_cap;
    logic              w_stable;
    logic              w_restart;
    logic              w_new_cmd;
    logic              w_capture;
    logic              w_settle;
    logic [3:0]        w_idx;
    logic              w_idx_valid;

    pio_word_stability #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stability (
        .clk          (clk),
        .reset        (reset),
        .i_pio_word   (pio_word),
        .i_capture    (w_capture),
        .i_settle     (w_settle),
        .o_word_toggle(w_word_toggle),
        .o_cap        (w_cap),
        .o_stable     (w_stable),
        .o_restart    (w_restart)
    );

    assign w_new_cmd   = (w_word_toggle != r_last_toggle);
    assign w_idx       = word_idx(w_cap);
    assign w_idx_valid = ({1'b0, w_idx} < 5'(NUM_PARAMS));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_capture = 1'b0;
        w_settle  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_new_cmd) begin
                    w_capture = 1'b1;
                    w_state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A reverted toggle abandons the command; otherwise the
                // stability tracker restarts or counts on this same cycle.
                if (!w_new_cmd) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_settle = 1'b1;
                    if (!w_restart && w_stable) w_state_n = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_n = ST_IDLE;
            default:   w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) r_param[i] <= '0;
            r_update      <= '0;
            r_last_toggle <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_update <= '0;
            if (r_state == ST_COMMIT) begin
                if (word_rsv_set(w_cap)) begin
                    r_err <= 1'b1;
                end else if (w_idx_valid) begin
                    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                        if (w_idx == 4'(i)) begin
                            r_param[i]  <= w_cap[VALUE_W-1:0];
                            r_update[i] <= 1'b1;
                        end
                    end
                end else if (w_idx == IDX_CLR_ERR) begin
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
                r_last_toggle <= w_cap[TOGGLE_BIT];
                r_ack         <= w_cap[TOGGLE_BIT];
            end
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bus
        assign param_bus[g*VALUE_W +: VALUE_W] = r_param[g];
    end

    assign param_update = r_update;
    assign ack_toggle   = r_ack;
    assign cmd_err      = r_err;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pio_param_decoder.sv
// Bench for pio_param_decoder: directed vector table, hand-written corner
// sequences and randomized words against a run-length reference model.
module tb_pio_param_decoder;

    localparam int NP = 8;
    localparam int VW = 24;
    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pio_word;
    logic [NP*VW-1:0]  param_bus;
    logic [NP-1:0]     param_update;
    logic              ack_toggle;
    logic              busy;
    logic              cmd_err;

    always #5 clk = ~clk;

    pio_param_decoder #(
        .NUM_PARAMS   (NP),
        .VALUE_W      (VW),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pio_word    (pio_word),
        .param_bus   (param_bus),
        .param_update(param_update),
        .ack_toggle  (ack_toggle),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int g_pulses = 0;

    // Reference model: a command commits once the captured word has been seen
    // in the sampled register for SC+1 consecutive samples with its toggle
    // still differing from the last acknowledged one.
    localparam int M_IDLE = 0, M_RUN = 1, M_COMMIT = 2;
    int          m_mode;
    int          m_run;
    logic [31:0] m_wq, m_cap;
    logic        m_last, m_ack, m_err;
    logic [23:0] m_param [NP];
    logic [NP-1:0] m_upd;

    task automatic check(input string name, input logic [NP*VW-1:0] act, input logic [NP*VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [31:0] sampled);
        int idx;
        m_upd = '0;
        if (rst) begin
            m_mode = M_IDLE; m_run = 0; m_wq = '0; m_cap = '0;
            m_last = 1'b0; m_ack = 1'b0; m_err = 1'b0;
            for (int i = 0; i < NP; i++) m_param[i] = '0;
            return;
        end
        if (m_mode == M_COMMIT) begin
            idx = int'(m_cap[30:27]);
            if (m_cap[26:24] != 3'd0) m_err = 1'b1;
            else if (idx < NP) begin
                m_param[idx] = m_cap[23:0];
                m_upd = NP'(1) << idx;
            end else if (idx == 15) m_err = 1'b0;
            else m_err = 1'b1;
            m_last = m_cap[31];
            m_ack  = m_cap[31];
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (m_wq[31] != m_last) begin
                m_mode = M_RUN; m_cap = m_wq; m_run = 1;
            end
        end else begin
            if (m_wq[31] == m_last) m_mode = M_IDLE;
            else if (m_wq != m_cap) begin
                m_cap = m_wq; m_run = 1;
            end else begin
                m_run++;
                if (m_run == SC + 1) m_mode = M_COMMIT;
            end
        end
        m_wq = sampled;
    endtask

    task automatic step(input logic [31:0] w, input logic rst);
        logic [NP*VW-1:0] exp_bus;
        pio_word = w;
        reset    = rst;
        @(posedge clk);
        model_edge(rst, w);
        #1;
        for (int i = 0; i < NP; i++) exp_bus[i*VW +: VW] = m_param[i];
        check("param_bus", param_bus, exp_bus);
        check("param_update", NP*VW'(param_update), NP*VW'(m_upd));
        check("ack_toggle", NP*VW'(ack_toggle), NP*VW'(m_ack));
        check("busy", NP*VW'(busy), NP*VW'(m_mode != M_IDLE));
        check("cmd_err", NP*VW'(cmd_err), NP*VW'(m_err));
        g_pulses += $countones(param_update);
    endtask

    typedef struct {
        logic [31:0] word;
        int          hold;
        logic        exp_ack;
        logic        exp_err;
        int          chk_idx;
        logic [23:0] exp_val;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] w;
        int hold;
        logic [NP*VW-1:0] bus_snap;

        vecs[0] = '{32'h0000_0000, 20, 1'b0, 1'b0, 1, 24'h000000, 0};
        vecs[1] = '{32'h8D00_0001, 10, 1'b1, 1'b1, 1, 24'h000000, 0};
        vecs[2] = '{32'h7800_0000, 10, 1'b0, 1'b0, 1, 24'h000000, 0};
        vecs[3] = '{32'h8812_3456, 10, 1'b1, 1'b0, 1, 24'h123456, 1};
        vecs[4] = '{32'h4800_0777, 10, 1'b0, 1'b1, 1, 24'h123456, 0};
        vecs[5] = '{32'hF800_0000, 10, 1'b1, 1'b0, 1, 24'h123456, 0};
        vecs[6] = '{32'h38FF_FFFF, 10, 1'b0, 1'b0, 7, 24'hFFFFFF, 1};
        vecs[7] = '{32'h8000_0000, 10, 1'b1, 1'b0, 0, 24'h000000, 1};

        pio_word = '0;
        reset    = 1'b1;
        step(32'h0, 1'b1);
        step(32'h0, 1'b1);
        check("reset_bus", param_bus, '0);
        check("reset_ack_busy_err", NP*VW'({ack_toggle, busy, cmd_err, param_update}), '0);

        for (int v = 0; v < 8; v++) begin
            g_pulses = 0;
            for (int c = 0; c < vecs[v].hold; c++) step(vecs[v].word, 1'b0);
            check($sformatf("vec%0d_ack", v), NP*VW'(ack_toggle), NP*VW'(vecs[v].exp_ack));
            check($sformatf("vec%0d_err", v), NP*VW'(cmd_err), NP*VW'(vecs[v].exp_err));
            check($sformatf("vec%0d_param", v), NP*VW'(param_bus[vecs[v].chk_idx*VW +: VW]),
                  NP*VW'(vecs[v].exp_val));
            check($sformatf("vec%0d_pulses", v), NP*VW'(g_pulses), NP*VW'(vecs[v].exp_pulses));
        end

        // Value change mid-settle restarts the stability count.
        g_pulses = 0;
        for (int c = 0; c < 3; c++) step(32'h10AA_AAAA, 1'b0);
        for (int c = 0; c < 6; c++) step(32'h10BB_BBBB, 1'b0);
        check("restart_no_early_pulse", NP*VW'(g_pulses), '0);
        step(32'h10BB_BBBB, 1'b0);
        check("restart_pulse", NP*VW'(param_update), NP*VW'(8'h04));
        check("restart_param2", NP*VW'(param_bus[2*VW +: VW]), NP*VW'(24'hBBBBBB));
        for (int c = 0; c < 3; c++) step(32'h10BB_BBBB, 1'b0);
        check("restart_single_pulse", NP*VW'(g_pulses), NP*VW'(1));

        // Toggle reverted during settle: no commit, ack unchanged.
        g_pulses = 0;
        for (int c = 0; c < 3; c++) step(32'hC800_0123, 1'b0);
        check("revert_busy", NP*VW'(busy), NP*VW'(1));
        for (int c = 0; c < 10; c++) step(32'h4800_0123, 1'b0);
        check("revert_ack", NP*VW'(ack_toggle), '0);
        check("revert_idle", NP*VW'(busy), '0);
        check("revert_no_pulse", NP*VW'(g_pulses), '0);

        // Reset mid-settle aborts; the held word is re-detected afterwards.
        g_pulses = 0;
        for (int c = 0; c < 3; c++) step(32'h9833_3333, 1'b0);
        step(32'h9833_3333, 1'b1);
        step(32'h9833_3333, 1'b1);
        check("rst_abort_bus", param_bus, '0);
        check("rst_abort_pulses", NP*VW'(g_pulses), '0);
        for (int c = 0; c < 6; c++) step(32'h9833_3333, 1'b0);
        check("rst_no_early_pulse", NP*VW'(g_pulses), '0);
        step(32'h9833_3333, 1'b0);
        check("rst_pulse3", NP*VW'(param_update), NP*VW'(8'h08));
        check("rst_param3", NP*VW'(param_bus[3*VW +: VW]), NP*VW'(24'h333333));
        check("rst_ack", NP*VW'(ack_toggle), NP*VW'(1));

        // Randomized words held for random durations, occasional reset.
        for (int b = 0; b < 60; b++) begin
            w[31]    = 1'($urandom_range(0, 1));
            w[30:27] = 4'($urandom_range(0, 15));
            w[26:24] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            w[23:0]  = 24'($urandom);
            hold     = int'($urandom_range(1, 9));
            for (int c = 0; c < hold; c++) step(w, ($urandom_range(0, 59) == 0));
        end

        bus_snap = param_bus;
        for (int c = 0; c < 12; c++) step(w, 1'b0);
        check("final_busy", NP*VW'(busy), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_param_decoder.md
# pio_param_decoder

Downstream consumer of the 32-bit control-value PIO. Software writes a packed command word (toggle, index, value) to the PIO output port. This block registers the word and requires it to be stable for a set number of cycles before committing the value into one of NUM_PARAMS parameter registers. It then returns an acknowledge toggle, routed to a PIO input bit, so the JTAG-UART control software can confirm each write.

## Interface
- NUM_PARAMS, 8 — number of parameter registers; legal range 1..15; index 15 is reserved.
- VALUE_W, 24 — parameter width; fixed at 24 by the word format.
- STABLE_CYCLES, 4 — cycles the word must stay identical before commit; legal range 1..255.

- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- pio_word  in  32  PIO port value: [31] request toggle, [30:27] index, [26:24] reserved (must be 0), [23:0] value.
- param_bus  out  NUM_PARAMS*24  concatenated parameter registers; param i occupies [24*i+23:24*i].
- param_update  out  NUM_PARAMS  one-cycle pulse on bit i when param i is written.
- ack_toggle  out  1  copies the committed request toggle; routed to a PIO input bit.
- busy  out  1  high while in SETTLE or COMMIT.
- cmd_err  out  1  sticky error flag.

## Operation
- pio_word is registered into word_q before any use. Undriven or tristated PIO bits are resolved at top level, not here.
- A new command exists when word_q[31] != last_toggle.
- FSM states: IDLE, SETTLE, COMMIT.
- IDLE:
  - On a new command: cap <= word_q, cnt <= 1, go to SETTLE.
- SETTLE, one branch per cycle:
  - If word_q[31] == last_toggle (toggle reverted): go to IDLE with no commit.
  - Else if word_q != cap: cap <= word_q, cnt <= 1 (restart the count).
  - Else if cnt == STABLE_CYCLES: go to COMMIT.
  - Else: cnt <= cnt + 1.
- COMMIT (exactly one cycle):
  - Reserved bits nonzero: cmd_err <= 1, no register write.
  - Index < NUM_PARAMS: write param[index] <= cap[23:0] and pulse param_update[index].
  - Index == 15: clear cmd_err; no parameter write.
  - Any other index: cmd_err <= 1, no register write.
  - In every case: last_toggle <= cap[31], ack_toggle <= cap[31], then go to IDLE.
- The ack is toggled even for error commands, so software never deadlocks; software checks cmd_err separately.
- Rewriting a parameter with its current value still pulses param_update.
- cmd_err set and clear are never simultaneous: a reserved-bit error is checked before the index decode.

## Timing
- Reset values: every param register 0, param_update 0, ack_toggle 0, busy 0, cmd_err 0, last_toggle 0, state IDLE, cnt 0.
- Define edge E0 as the clock edge at which a changed pio_word is first captured into word_q.
- With pio_word held stable, COMMIT is active in the cycle after edge E(STABLE_CYCLES+1). Its register writes, ack_toggle and last_toggle become visible after edge E(STABLE_CYCLES+2).
- param_update is a single registered pulse aligned with the new param_bus value.
- busy goes high after E1 and stays high through the COMMIT cycle.
- Minimum command spacing is STABLE_CYCLES+3 cycles. A toggle flip arriving during COMMIT is detected from IDLE on the following cycle.
- Reset asserted mid-SETTLE or mid-COMMIT aborts the command with no write; reset has priority over every transition.
- After reset, a pio_word with [31]=1 is treated as a new command.
- cnt is 8 bits wide; it saturates and never wraps.

## Structure
- Shared package contents:
  - Word-field bit positions: TOGGLE_BIT=31, IDX_MSB=30, IDX_LSB=27, RSV_MSB=26, RSV_LSB=24, VAL_W=24.
  - Reserved index constant IDX_CLR_ERR=15.
  - FSM state enum.
- One sub-module, pio_word_stability: owns word_q, cap and cnt, and outputs `stable` and `restart`. The FSM, the register file and the error logic stay in the top module.

## Test plan
- Reset, then pio_word=0x0000_0000 held 20 cycles -> no param_update, param_bus all 0, ack_toggle 0, busy 0.
- pio_word=0x8812_3456 (toggle 1, index 1, value 0x123456), STABLE_CYCLES=4 -> param[1]=0x123456 and param_update[1] pulse after E6, ack_toggle=1, other params unchanged.
- Toggle 1, index 2, value 0xAAAAAA, then the value changes to 0xBBBBBB after E2 -> count restarts; param[2]=0xBBBBBB, a single pulse, 4 stable cycles counted from the change.
- Word 0x8D00_0001 (reserved bits set) -> no write, cmd_err=1, ack_toggle toggles; then toggle-flipped index 15 (0x7800_0000) -> cmd_err=0.
- Index 9 with NUM_PARAMS=8 -> cmd_err=1, no param_update; the toggle flipped back after E2 -> return to IDLE, no commit, ack unchanged.
- Reset asserted during SETTLE of an index-3 write with toggle 1 -> no pulse during reset; after release the word is re-detected and param[3] is written after E6 counted from release.
